uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Serial front end for the 8-bit CPU's programming path. Receives a program image over a UART line (8N1), buffers a full image of `PROG_BYTES` bytes, then drives the CPU's programming handshake, presenting one byte per request on the byte lane that feeds `ui_in`. It sits directly upstream of the CPU top. Its outputs connect to `ui_in` and `uio_in[0]`. Its inputs come from `uio_out[1]` (ready) and `uio_out[2]` (done_load).

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; must be at least 4.
- `PROG_BYTES`, 16, image size in bytes; the buffer is `PROG_BYTES` x 8.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input 1: UART receive line, idle high, asynchronous to `clk`.
- `cpu_ready` input 1: CPU ready-for-byte; the CPU reads the byte lane while this is high.
- `cpu_done_load` input 1: CPU reports that programming is complete.
- `ui_byte` output 8: byte lane to the CPU `ui_in`.
- `programming` output 1: programming-mode request to the CPU.
- `busy` output 1: high in the LOAD state.
- `load_done` output 1: one-cycle pulse when an image finishes.
- `frame_err` output 1: sticky; a stop bit (or parity, if enabled) was bad.
- `overflow` output 1: sticky; a byte arrived while not in FILL and was dropped.
- `underrun` output 1: sticky; the CPU requested more than `PROG_BYTES` bytes.

## Operation
- `rx` passes through a 2-flop synchronizer.
- Receiver FSM: R_IDLE, R_START, R_DATA, (R_PAR), R_STOP.
  - R_IDLE: a falling edge of synced `rx` moves to R_START.
  - R_START: at `CLKS_PER_BIT/2`, `rx` is re-sampled. If it is high (glitch), return to R_IDLE. Otherwise go to R_DATA.
  - R_DATA: 8 samples, one every `CLKS_PER_BIT`, LSB first.
  - R_STOP: a stop sample of 0 sets `frame_err` and discards the byte. A good byte is written to the buffer.
- Loader FSM: FILL, LOAD, DONE.
  - FILL: received bytes are written at `wr_ptr`, which then increments. When `wr_ptr` reaches `PROG_BYTES`, go to LOAD.
  - LOAD: `programming`=1 and `busy`=1. `ui_byte` = `buf[rd_ptr]`. A falling edge of `cpu_ready` (registered 1, current 0) increments `rd_ptr`.
  - LOAD, excess requests: if `cpu_ready` rises while `rd_ptr`==`PROG_BYTES`, `ui_byte` = 0x00 and `underrun` is set.
  - LOAD exit: when `cpu_done_load` is sampled high, go to DONE.
  - DONE (one cycle): `programming`=0, `load_done`=1. `wr_ptr` and `rd_ptr` are cleared. Return to FILL.
- A good byte completing in LOAD or DONE is dropped and sets `overflow`. The receiver itself keeps running in all states.
- Sticky flags clear only on `rst`.
- Reset (at any time, including mid-frame or mid-LOAD):
  - all outputs go to 0 and `ui_byte` = 0x00;
  - both FSMs go idle (R_IDLE, FILL);
  - pointers are cleared;
  - buffer contents are don't-care.

## Timing
- Bit sample point: mid-bit, `CLKS_PER_BIT/2` + k·`CLKS_PER_BIT` cycles after the synced start edge. The synchronizer adds 2 cycles.
- Buffer write happens in the cycle after the stop-bit sample.
- LOAD entry: `programming` rises 1 cycle after the final buffer write.
- `ui_byte` is registered. It updates 1 cycle after a `rd_ptr` change and holds stable for the whole period `cpu_ready` is high.
- `cpu_done_load` to `programming` low: 1 cycle, together with the `load_done` pulse.
- `cpu_ready` and `cpu_done_load` are synchronous to `clk`; they are not synchronized.
- If `cpu_ready` falls and `cpu_done_load` rises in the same cycle: `rd_ptr` increments and DONE is still taken.

## Configuration
- `LOADER_PARITY_EN` defined:
  - Frame is 8E1: an even-parity bit follows the data bits (R_PAR).
  - A parity mismatch sets `frame_err` and drops the byte.
- `LOADER_PARITY_EN` undefined:
  - Frame is 8N1; the R_PAR state is not compiled in.

## Test plan
- Reset mid-frame: assert `rst` during the 4th data bit, then send 0x5A. Required: the first complete byte written is 0x5A, and all outputs are 0 during reset.
- Full load with default parameters: send 0x00..0x0F, then give 16 `cpu_ready` pulses and a `cpu_done_load` pulse. Required:
  - `programming` rises 1 cycle after the 16th stop bit;
  - `ui_byte` sequence is 0x00..0x0F;
  - `load_done` pulses once and `programming` falls.
- Bad stop bit: send 0xA5 with stop=0. Required: `frame_err`=1, the byte is not stored, `wr_ptr` is unchanged, and the next good byte lands at the same index.
- Overflow/underrun: during LOAD, send 0x33 and issue a 17th `cpu_ready`. Required: `overflow`=1, `underrun`=1, `ui_byte`=0x00 on the 17th request.
- Glitch rejection: a 3-cycle low pulse on `rx`. Required: no byte is received and no flags are set.
- With `LOADER_PARITY_EN` defined: send 0x07 with parity=0. Required: `frame_err`=1 and the byte is dropped. Send 0x07 with parity=1. Required: the byte is stored.

Source files
------------

// File: rtl/uart_program_loader.sv
// UART receiver that buffers a PROG_BYTES program image, then serves it byte-by-byte to the CPU.
// Frame is 8N1 by default; define LOADER_PARITY_EN for 8E1 (even parity checked, bad parity drops the byte).
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PROG_BYTES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       cpu_ready,
  input  logic       cpu_done_load,
  output logic [7:0] ui_byte,
  output logic       programming,
  output logic       busy,
  output logic       load_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       underrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(PROG_BYTES + 1);
  localparam int AW = (PROG_BYTES > 1) ? $clog2(PROG_BYTES) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] LAST    = PW'(PROG_BYTES);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef LOADER_PARITY_EN
    R_PAR,
`endif
    R_STOP
  } rstate_t;

  typedef enum logic [1:0] {FILL, LOAD, DONE} lstate_t;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_q, rx_fall;
  rstate_t       rstate, rnext;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, par_bad, stop_ok, stop_bad, rx_done;

  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else     {rx_s1, rx_s2, rx_q} <= {rx, rx_s1, rx_s2};

  assign rx_fall = rx_q & ~rx_s2;
  assign tick    = (rstate == R_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

  always_ff @(posedge clk or posedge rst)
    if (rst) rstate <= R_IDLE;
    else     rstate <= rnext;

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (rx_fall) rnext = R_START;
      R_START: if (tick) rnext = rx_s2 ? R_IDLE : R_DATA;
`ifdef LOADER_PARITY_EN
      R_DATA:  if (tick && bit_idx == 3'd7) rnext = R_PAR;
      R_PAR:   if (tick) rnext = R_STOP;
`else
      R_DATA:  if (tick && bit_idx == 3'd7) rnext = R_STOP;
`endif
      R_STOP:  if (tick) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (rstate == R_STOP && tick) begin
      stop_ok  = rx_s2 & ~par_bad;
      stop_bad = ~(rx_s2 & ~par_bad);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= stop_ok;
      if (rstate == R_IDLE || tick) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (rstate == R_START) bit_idx <= '0;
      if (rstate == R_DATA && tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end

`ifdef LOADER_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even count of ones.
  always_ff @(posedge clk or posedge rst)
    if (rst)                          par_bad <= 1'b0;
    else if (rstate == R_PAR && tick) par_bad <= ^{shreg, rx_s2};
`else
  assign par_bad = 1'b0;
`endif

  // ---------------- loader ----------------
  lstate_t       lstate, lnext;
  logic [7:0]    mem [PROG_BYTES];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          ready_q, ready_fall, ready_rise, store;

  assign ready_fall = ready_q & ~cpu_ready;
  assign ready_rise = cpu_ready & ~ready_q;
  assign store      = rx_done && lstate == FILL && wr_ptr != LAST;

  always_ff @(posedge clk or posedge rst)
    if (rst) lstate <= FILL;
    else     lstate <= lnext;

  always_comb begin
    lnext = lstate;
    case (lstate)
      FILL:    if (wr_ptr == LAST) lnext = LOAD;
      LOAD:    if (cpu_done_load) lnext = DONE;
      DONE:    lnext = FILL;
      default: lnext = FILL;
    endcase
  end

  always_comb begin
    programming = (lstate == LOAD);
    busy        = (lstate == LOAD);
    load_done   = (lstate == DONE);
  end

  always_ff @(posedge clk)
    if (store) mem[wr_ptr[AW-1:0]] <= shreg;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_q   <= 1'b0;
      ui_byte   <= 8'h00;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      ready_q <= cpu_ready;
      if (stop_bad)          frame_err <= 1'b1;
      if (rx_done && !store) overflow  <= 1'b1;
      case (lstate)
        FILL: if (store) wr_ptr <= wr_ptr + 1'b1;
        LOAD: begin
          if (ready_fall && rd_ptr != LAST) rd_ptr   <= rd_ptr + 1'b1;
          if (ready_rise && rd_ptr == LAST) underrun <= 1'b1;
        end
        DONE: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        default: ;
      endcase
      // Past the end of the image the lane reads as zero.
      ui_byte <= (lstate == LOAD && rd_ptr != LAST) ? mem[rd_ptr[AW-1:0]] : 8'h00;
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized scoreboard bench for uart_program_loader: image model in queues, monitor checks each CPU request.
`timescale 1ns/1ps
module tb_uart_program_loader;
  localparam int CPB = 16;
  localparam int N   = 16;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, cpu_ready = 1'b0, cpu_done_load = 1'b0;
  logic [7:0] ui_byte;
  logic       programming, busy, load_done, frame_err, overflow, underrun;

  int total = 0, bad = 0, ld_cnt = 0, req_idx = 0;
  logic [7:0] img[$];
  logic [7:0] exp_q[$];
  logic exp_fe = 1'b0, exp_ovf = 1'b0, exp_unr = 1'b0;
  logic rdy_d = 1'b0;
  logic [7:0] mon_e;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .PROG_BYTES(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cpu_ready(cpu_ready), .cpu_done_load(cpu_done_load),
    .ui_byte(ui_byte), .programming(programming), .busy(busy), .load_done(load_done),
    .frame_err(frame_err), .overflow(overflow), .underrun(underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, " frame_err"}, frame_err, exp_fe);
    check({tag, " overflow"},  overflow,  exp_ovf);
    check({tag, " underrun"},  underrun,  exp_unr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ui_byte"},     ui_byte,     0);
    check({tag, " programming"}, programming, 0);
    check({tag, " busy"},        busy,        0);
    check({tag, " load_done"},   load_done,   0);
    check({tag, " frame_err"},   frame_err,   0);
    check({tag, " overflow"},    overflow,    0);
    check({tag, " underrun"},    underrun,    0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input logic last);
    rx = 1'b0; cycles(CPB);
    for (int i = 0; i < 8; i++) begin rx = d[i]; cycles(CPB); end
`ifdef LOADER_PARITY_EN
    rx = par_b; cycles(CPB);
`endif
    if (last) check("programming before final stop", programming, 0);
    rx = stop_b; cycles(CPB);
    if (last) check("programming after final stop", programming, 1);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    logic last;
    last = (img.size() == N - 1);
    if (img.size() < N) img.push_back(d);
    else exp_ovf = 1'b1;
    send_frame(d, 1'b1, ^d, last);
    cycles(CPB);
  endtask

  task automatic request(input logic with_done);
    exp_q.push_back(req_idx < img.size() ? img[req_idx] : 8'h00);
    if (req_idx >= N) exp_unr = 1'b1;
    req_idx++;
    cpu_ready = 1'b1; cycles(3);
    cpu_ready = 1'b0; cpu_done_load = with_done; cycles(1);
    cpu_done_load = 1'b0;
    if (with_done) begin
      check("load_done on done", load_done, 1);
      check("programming off on done", programming, 0);
    end
    cycles(2);
  endtask

  task automatic finish_load(input logic simultaneous);
    int ld0;
    ld0 = ld_cnt;
    if (simultaneous) request(1'b1);
    else begin
      cpu_done_load = 1'b1; cycles(1);
      cpu_done_load = 1'b0;
      check("load_done on done", load_done, 1);
      check("programming off on done", programming, 0);
    end
    cycles(3);
    check("load_done pulse count", ld_cnt - ld0, 1);
    check("busy after done", busy, 0);
    check("scoreboard drained", exp_q.size(), 0);
    img.delete();
    req_idx = 0;
  endtask

  // Monitor: every rising cpu_ready presents one byte on ui_byte.
  always @(negedge clk) begin
    if (load_done) ld_cnt++;
    if (cpu_ready && !rdy_d) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ui_byte: unexpected request, got %0h expected none", ui_byte);
      end else begin
        mon_e = exp_q.pop_front();
        check("ui_byte", ui_byte, mon_e);
        check("busy during request", busy, 1);
      end
    end
    rdy_d = cpu_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(CPB);

    // Image 1: 0x00..0x0F with a glitch and a bad-stop byte mixed in.
    rx = 1'b0; cycles(3); rx = 1'b1; cycles(3 * CPB);
    check_flags("after glitch");
    check("programming after glitch", programming, 0);
    for (int i = 0; i < N; i++) begin
      if (i == 5) begin
        send_frame(8'hA5, 1'b0, ^8'hA5, 1'b0);
        cycles(CPB);
        exp_fe = 1'b1;
        check_flags("after bad stop");
        check("programming after bad stop", programming, 0);
      end
      send_good(8'(i));
    end
    check("busy in load", busy, 1);
    for (int i = 0; i < N; i++) request(1'b0);
    send_good(8'h33);
    check_flags("after overflow byte");
    request(1'b0);
    check_flags("after 17th request");
    finish_load(1'b0);

    // Partial image, then reset in the middle of the 4th data bit.
    for (int i = 0; i < 7; i++) send_good(8'($urandom));
    rx = 1'b0; cycles(CPB);
    for (int i = 0; i < 3; i++) begin rx = 1'($urandom); cycles(CPB); end
    rx = 1'($urandom); cycles(CPB / 2);
    rst = 1'b1; rx = 1'b1; cycles(2);
    check_all_zero("mid-frame reset");
    cycles(2 * CPB);
    rst = 1'b0;
    img.delete(); req_idx = 0;
    exp_fe = 1'b0; exp_ovf = 1'b0; exp_unr = 1'b0;
    cycles(CPB);
    check_flags("after reset release");

    // Image 2: 0x5A first, random rest; last request ends with done in the same cycle.
    send_good(8'h5A);
`ifdef LOADER_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    cycles(CPB);
    exp_fe = 1'b1;
    check_flags("after bad parity");
    send_good(8'h07);
`endif
    while (img.size() < N) send_good(8'($urandom));
    for (int i = 0; i < N - 1; i++) request(1'b0);
    finish_load(1'b1);
    check_flags("after image 2");

    // Image 3: pointers must restart at zero after the combined fall/done cycle.
    for (int i = 0; i < N; i++) send_good(8'($urandom));
    for (int i = 0; i < N; i++) request(1'b0);
    finish_load(1'b0);
    check_flags("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
